// File: rtl/arith_seq_unit.sv
// Arithmetic half of the ALU: single-cycle signed ADD/SUB, and signed MUL/MULH
// computed by an iterative shift-add over WL cycles. Uses a start/busy/done handshake.
module arith_seq_unit #(
    parameter int WL = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [1:0]    opSel,
    input  logic [WL-1:0] Ain,
    input  logic [WL-1:0] Bin,
    output logic [WL-1:0] Aout,
    output logic          busy,
    output logic          done,
    output logic          ovf,
    output logic          zero,
    output logic [1:0]    dbg_state
);

    // Handshake: start is sampled on every rising edge and is accepted only while
    // busy=0 (IDLE or DONE). Operands and opSel are captured at the accepting edge.
    // busy is high while a multiply iterates. done is high for exactly one cycle
    // after each result write. busy and done are never high together.

    localparam int CW = (WL > 1) ? $clog2(WL) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [2*WL-1:0] acc;
    logic [2*WL-1:0] mcand;
    logic [WL-1:0]   mplier;
    logic [CW-1:0]   cnt;
    logic            neg_q;
    logic            mulh_q;

    logic            accept;
    logic            last_iter;
    logic [WL-1:0]   sum, diff, addsub_res;
    logic            addsub_ovf;
    logic [WL-1:0]   a_mag, b_mag;
    logic [2*WL-1:0] addend, acc_nxt, prod;
    logic [WL-1:0]   mul_res;
    logic            mul_ovf;

    assign busy      = (state == MUL);
    assign done      = (state == DONE);
    assign dbg_state = state;
    assign last_iter = (state == MUL) && (cnt == CW'(WL - 1));

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = opSel[1] ? MUL : DONE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            MUL: begin
                if (last_iter) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sum        = Ain + Bin;
        diff       = Ain - Bin;
        addsub_res = opSel[0] ? diff : sum;
        if (opSel[0])
            addsub_ovf = (Ain[WL-1] != Bin[WL-1]) && (addsub_res[WL-1] != Ain[WL-1]);
        else
            addsub_ovf = (Ain[WL-1] == Bin[WL-1]) && (addsub_res[WL-1] != Ain[WL-1]);
        // The most negative value negates to itself, which read unsigned is 2^(WL-1).
        a_mag = Ain[WL-1] ? (~Ain + 1'b1) : Ain;
        b_mag = Bin[WL-1] ? (~Bin + 1'b1) : Bin;
    end

    always_comb begin
        addend  = mplier[0] ? mcand : '0;
        acc_nxt = acc + addend;
        prod    = neg_q ? (~acc_nxt + 1'b1) : acc_nxt;
        mul_res = mulh_q ? prod[2*WL-1:WL] : prod[WL-1:0];
        mul_ovf = mulh_q ? 1'b0 : (prod[2*WL-1:WL] != {WL{prod[WL-1]}});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Aout   <= '0;
            ovf    <= 1'b0;
            zero   <= 1'b1;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            neg_q  <= 1'b0;
            mulh_q <= 1'b0;
        end else if (accept) begin
            if (!opSel[1]) begin
                Aout <= addsub_res;
                ovf  <= addsub_ovf;
                zero <= (addsub_res == '0);
            end else begin
                mcand  <= {{WL{1'b0}}, a_mag};
                mplier <= b_mag;
                neg_q  <= Ain[WL-1] ^ Bin[WL-1];
                mulh_q <= opSel[0];
                acc    <= '0;
                cnt    <= '0;
            end
        end else if (state == MUL) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (last_iter) begin
                Aout <= mul_res;
                ovf  <= mul_ovf;
                zero <= (mul_res == '0);
            end
        end
    end

endmodule

// File: tb/tb_arith_seq_unit.sv
// Directed self-checking bench for arith_seq_unit (WL=32): add/sub, mul/mulh,
// back-to-back issue, start-while-busy and asynchronous reset.
module tb_arith_seq_unit;

    localparam int WL = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [1:0]    opSel;
    logic [WL-1:0] Ain, Bin;
    logic [WL-1:0] Aout;
    logic          busy, done, ovf, zero;
    logic [1:0]    dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    arith_seq_unit #(.WL(WL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opSel(opSel),
        .Ain(Ain), .Bin(Bin), .Aout(Aout), .busy(busy), .done(done),
        .ovf(ovf), .zero(zero), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one multiply, then counts busy cycles and checks Aout holds throughout.
    task automatic run_mul(input logic [1:0] op, input logic [WL-1:0] a, input logic [WL-1:0] b,
                           output int cycles, output int held);
        logic [WL-1:0] prev;
        prev  = Aout;
        start = 1'b1; opSel = op; Ain = a; Bin = b;
        tick();
        start = 1'b0;
        cycles = 0;
        held   = 1;
        while (busy && cycles < 100) begin
            if (Aout !== prev || done !== 1'b0) held = 0;
            cycles++;
            tick();
        end
    endtask

    int cyc, held, dones;

    initial begin
        rst_n = 1'b1; start = 1'b0; opSel = 2'b00; Ain = '0; Bin = '0;

        // Reset takes effect before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        check("rst_aout", Aout, 32'h0);
        check("rst_zero", {31'b0, zero}, 32'd1);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_ovf", {31'b0, ovf}, 32'd0);
        check("rst_state", {30'b0, dbg_state}, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // ADD overflow, then SUB issued in the DONE cycle.
        start = 1'b1; opSel = 2'b00; Ain = 32'h7FFF_FFFF; Bin = 32'h0000_0001;
        tick();
        check("add_aout", Aout, 32'h8000_0000);
        check("add_ovf", {31'b0, ovf}, 32'd1);
        check("add_zero", {31'b0, zero}, 32'd0);
        check("add_done", {31'b0, done}, 32'd1);
        opSel = 2'b01; Ain = 32'd5; Bin = 32'd5;
        tick();
        start = 1'b0;
        check("sub_aout", Aout, 32'h0);
        check("sub_zero", {31'b0, zero}, 32'd1);
        check("sub_ovf", {31'b0, ovf}, 32'd0);
        check("sub_done", {31'b0, done}, 32'd1);
        tick();
        check("sub_done_end", {31'b0, done}, 32'd0);
        check("idle_state", {30'b0, dbg_state}, 32'd0);

        // -3 x 7
        run_mul(2'b10, 32'hFFFF_FFFD, 32'd7, cyc, held);
        check("mul_busy_cycles", cyc, 32'd32);
        check("mul_hold", held, 32'd1);
        check("mul_done", {31'b0, done}, 32'd1);
        check("mul_aout", Aout, 32'hFFFF_FFEB);
        check("mul_ovf", {31'b0, ovf}, 32'd0);
        check("mul_zero", {31'b0, zero}, 32'd0);
        tick();
        check("mul_done_end", {31'b0, done}, 32'd0);
        run_mul(2'b11, 32'hFFFF_FFFD, 32'd7, cyc, held);
        check("mulh_busy_cycles", cyc, 32'd32);
        check("mulh_aout", Aout, 32'hFFFF_FFFF);
        check("mulh_ovf", {31'b0, ovf}, 32'd0);

        // 2^16 x 2^16, then most-negative x -1.
        run_mul(2'b10, 32'h0001_0000, 32'h0001_0000, cyc, held);
        check("mul_big_aout", Aout, 32'h0);
        check("mul_big_ovf", {31'b0, ovf}, 32'd1);
        check("mul_big_zero", {31'b0, zero}, 32'd1);
        run_mul(2'b11, 32'h0001_0000, 32'h0001_0000, cyc, held);
        check("mulh_big_aout", Aout, 32'h0000_0001);
        check("mulh_big_ovf", {31'b0, ovf}, 32'd0);
        check("mulh_big_zero", {31'b0, zero}, 32'd0);
        run_mul(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, cyc, held);
        check("mul_min_aout", Aout, 32'h8000_0000);
        check("mul_min_ovf", {31'b0, ovf}, 32'd1);
        tick();

        // Start while busy is ignored; inputs changed mid-multiply have no effect.
        start = 1'b1; opSel = 2'b10; Ain = 32'd6; Bin = 32'd7;
        tick();
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (i == 3) begin start = 1'b1; opSel = 2'b00; Ain = 32'd1; Bin = 32'd1; end
            if (i == 4) begin start = 1'b0; Ain = 32'd9; Bin = 32'd9; end
            if (i == 10) check("busy_hold_aout", Aout, 32'h8000_0000);
            if (done) dones++;
            if (done && busy) dones += 100;
            tick();
        end
        check("busy_ign_aout", Aout, 32'd42);
        check("busy_ign_dones", dones, 32'd1);
        check("busy_ign_ovf", {31'b0, ovf}, 32'd0);

        // Reset during iteration 10 aborts the multiply.
        start = 1'b1; opSel = 2'b10; Ain = 32'd6; Bin = 32'd7;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst_n = 1'b0;
        #1;
        check("abort_aout", Aout, 32'h0);
        check("abort_zero", {31'b0, zero}, 32'd1);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        tick();
        rst_n = 1'b1;
        start = 1'b1; opSel = 2'b00; Ain = 32'd2; Bin = 32'd3;
        tick();
        start = 1'b0;
        check("post_rst_add_aout", Aout, 32'd5);
        check("post_rst_add_done", {31'b0, done}, 32'd1);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done || busy) dones++;
        end
        check("post_rst_quiet", dones, 32'd0);
        check("post_rst_hold", Aout, 32'd5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
